// File: rtl/seq_booth_divider.sv
// Iterative signed/unsigned divider. One quotient bit per clock using
// non-restoring division on operand magnitudes, followed by a single sign-fix
// cycle. Driven by a start/busy/done handshake.
module seq_booth_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Partial remainder is WIDTH+1 bits two's complement; p_q[WIDTH] is its sign.
  logic [WIDTH:0]   p_q, p_d;
  // Dividend magnitude shifts out of a_q while quotient bits shift in.
  logic [WIDTH-1:0] a_q, a_d;
  // Divisor magnitude.
  logic [WIDTH-1:0] d_q, d_d;
  // Operand signs, already qualified by is_signed (always 0 in unsigned mode).
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  // Datapath helpers for one non-restoring step and the final restore.
  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] r_fix;
  logic             divisor_zero;
  logic             in_dvd_neg;
  logic             in_dvs_neg;

  assign p_sh         = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign p_step       = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
  // The restored remainder lies in [0, D) so WIDTH bits hold it exactly.
  assign r_fix        = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
  assign divisor_zero = (d_q == '0);
  assign in_dvd_neg   = is_signed & dividend[WIDTH-1];
  assign in_dvs_neg   = is_signed & divisor[WIDTH-1];

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    a_d       = a_q;
    d_d       = d_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;

    case (state_q)
      // DONE accepts a new request exactly like IDLE for back-to-back issue.
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_neg_d = in_dvd_neg;
          dvs_neg_d = in_dvs_neg;
          // |MIN| = 2^(WIDTH-1) is representable as a WIDTH-bit magnitude.
          a_d       = in_dvd_neg ? (-dividend) : dividend;
          d_d       = in_dvs_neg ? (-divisor) : divisor;
          p_d       = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = S_CALC;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_CALC: begin
        p_d   = p_step;
        a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // With D = 0 the datapath yields all-ones and |dividend|; skipping the
        // quotient negation and keeping the remainder sign restore gives back
        // the original dividend.
        quo_d   = (dvd_neg_q ^ dvs_neg_q) && !divisor_zero ? (-a_q) : a_q;
        rem_d   = dvd_neg_q ? (-r_fix) : r_fix;
        dz_d    = divisor_zero;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: FSM and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: working registers are reset too, so an aborted operation leaves
      // no stale operands behind; they are plain flops, not a memory array.
      p_q       <= '0;
      a_q       <= '0;
      d_q       <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      p_q       <= p_d;
      a_q       <= a_d;
      d_q       <= d_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_booth_divider.sv
// Directed self-checking bench for seq_booth_divider (WIDTH = 32).
module tb_seq_booth_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  int busy_err = 0;

  seq_booth_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something outside the bounded waits stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request just after edge 0; returns just after edge 1 (accepting edge).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
  endtask

  // Count edges until done, starting from edge lat0; busy must stay high meanwhile.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_err++;
      tick();
      lat++;
    end
  endtask

  // Full operation with latency and result checks.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz);
    int lat;
    issue(sgn, a, b);
    wait_done(1, lat);
    check({tag, "_latency"}, lat, 34);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, edz);
    tick();
  endtask

  initial begin
    int lat;
    int seen_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // Unsigned 100 / 7 with explicit busy window and result hold.
    busy_err = 0;
    issue(1'b0, 32'd100, 32'd7);
    check("u100_busy_e1", busy, 1);
    wait_done(1, lat);
    check("u100_latency", lat, 34);
    check("u100_busy_window", busy_err, 0);
    check("u100_busy_at_done", busy, 0);
    check("u100_q", quotient, 32'd14);
    check("u100_r", remainder, 32'd2);
    check("u100_dz", div_by_zero, 0);
    tick();
    check("u100_done_pulse", done, 0);
    check("u100_q_hold", quotient, 32'd14);

    // Signed truncation toward zero.
    run_op("sneg_dvd", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op("sneg_dvs", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_op("sneg_7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    // Divide by zero, unsigned and signed negative dividend (no sign fix).
    run_op("dz_u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("dz_s", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Signed overflow wraps; also clears the previous divide-by-zero flag.
    run_op("min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("u_msb", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(1'b0, 32'd50, 32'd5);
    repeat (8) tick();
    start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    tick();
    start = 1'b0;
    wait_done(10, lat);
    check("ign_latency", lat, 34);
    check("ign_q", quotient, 32'd10);
    check("ign_r", remainder, 32'd0);
    issue(1'b0, 32'd9, 32'd2);
    wait_done(1, lat);
    check("b2b_latency", lat, 34);
    check("b2b_q", quotient, 32'd4);
    check("b2b_r", remainder, 32'd1);
    tick();

    // Asynchronous reset in the middle of CALC aborts the operation.
    issue(1'b1, 32'd1000, 32'd33);
    repeat (14) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_dz", div_by_zero, 0);
    #2;
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    check("arst_no_done", seen_done, 0);
    run_op("post_rst", 1'b1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
